fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the 5-stage pipeline; sits directly downstream of the hazard unit.
- Consumes the hazard unit's pc_en, stall_ifid and flush_ifid, plus redirect information from ID (jump) and EX/MEM (branch).
- Owns the PC register, the next-PC select, the instruction-memory read request and the IF/ID pipeline latch.
- Captures redirects that arrive while the PC is frozen, so they are never lost.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction/address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
pc_en  in  1  hazard unit permits PC advance
stall_ifid  in  1  hold IF/ID latch
flush_ifid  in  1  bubble IF/ID latch
ihit  in  1  imemload valid this cycle
imemload  in  WORD_W  instruction from icache
branch_taken  in  1  branch resolved taken
branch_target  in  WORD_W  branch destination
jump  in  1  jump/jr decoded in ID
jump_target  in  WORD_W  jump destination
halt  in  1  halt reached commit point
imemREN  out  1  instruction read request
imemaddr  out  WORD_W  current PC
ifid_instr  out  WORD_W  latched instruction
ifid_pc4  out  WORD_W  latched PC+4
ifid_valid  out  1  latch holds a real instruction
fetch_halted  out  1  state==HALTED
fetch_count  out  32  instructions loaded into IF/ID

Behaviour:
- Reset (async, RST=1):
  - pc=PC_INIT; state=RUN.
  - pend_valid=0, pend_target=0.
  - ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0.
  - imemREN=1, imemaddr=PC_INIT, fetch_halted=0.
  - Reset mid-operation discards any pending redirect and latched instruction.
- States:
  - RUN: imemREN=1.
  - HALTED: imemREN=0, PC frozen, no redirects captured.
  - RUN->HALTED on any edge with halt=1. HALTED exits only via RST.
- imemaddr=pc, combinational; imemREN=(state==RUN), combinational.
- advance = pc_en & ihit & state==RUN.
- Next-PC priority, evaluated on an advance edge:
  1. branch_taken -> branch_target
  2. jump -> jump_target
  3. pend_valid -> pend_target
  4. otherwise pc+4, modulo 2^WORD_W; 32'hFFFF_FFFC wraps to 0.
- Any advance edge clears pend_valid.
- Redirect capture, on an edge with state==RUN and advance=0:
  - branch_taken -> pend_target=branch_target, pend_valid=1. Overwrites any pending value.
  - else jump and (!pend_valid or pending entry is a jump) -> pend_target=jump_target, pend_valid=1.
  - A jump never overwrites a pending branch; track the entry type with a 1-bit pend_is_branch.
- Simultaneous branch_taken and jump: branch wins, because it is the older instruction.
- IF/ID latch, per edge, in priority order:
  1. state==HALTED or halt=1 -> instr=0, pc4=0, valid=0.
  2. flush_ifid -> instr=0, pc4=0, valid=0. Flush beats stall.
  3. stall_ifid -> hold all fields.
  4. ihit & state==RUN -> instr=imemload, pc4=pc+4, valid=1, fetch_count+=1 (wraps at 2^32).
  5. otherwise -> bubble: instr=0, pc4=0, valid=0.
- Latency: an instruction at PC appears in IF/ID on the edge where ihit=1 and the latch is not stalled or flushed. With ihit held at 1, one instruction per cycle.
- Halt beats a simultaneous redirect or advance: PC is not updated on the halt edge.

Test Plan:
- Reset then ihit=1, pc_en=1 for 4 cycles, PC_INIT=0:
  - imemaddr steps 0,4,8,C.
  - ifid_pc4 steps 4,8,C,10; ifid_valid=1.
  - fetch_count=4.
- ihit=0 for 3 cycles, pc=0x20:
  - imemaddr holds 0x20.
  - ifid_valid=0 (bubbles); fetch_count unchanged.
- pc_en=0 with branch_taken=1, target 0x100, for one cycle; then jump=1, target 0x200, while still stalled; then pc_en=1, ihit=1:
  - imemaddr becomes 0x100, not 0x200.
  - pend_valid clears.
- stall_ifid=1 and flush_ifid=1 on the same edge with ifid holding 0x8C010004 -> ifid_instr=0, ifid_valid=0.
- branch_taken=1 (0x40) and jump=1 (0x80) on an advance edge -> imemaddr=0x40.
- halt=1 while advancing from pc=0x30:
  - fetch_halted=1, imemREN=0, imemaddr stays 0x30, ifid_valid=0 thereafter.
  - Assert RST mid-HALTED -> imemaddr=PC_INIT, imemREN=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC select, imem request and IF/ID latch.
// Redirects that arrive while the PC is frozen are held until the next advance.
module fetch_unit #(
    parameter int WORD_W = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pc_en,
    input  logic              stall_ifid,
    input  logic              flush_ifid,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              halt,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc4,
    output logic              ifid_valid,
    output logic              fetch_halted,
    output logic [31:0]       fetch_count
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc4;
        logic              valid;
    } ifid_t;

    state_t            state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] next_pc;
    logic [WORD_W-1:0] pend_target;
    logic              pend_valid;
    logic              pend_is_branch;
    logic              running;
    logic              advance;
    logic              jump_capture;
    ifid_t             ifid;

    assign running  = (state == RUN);
    assign advance  = pc_en & ihit & running;
    assign pc_plus4 = pc + WORD_W'(4);

    // A queued jump may be replaced by a newer jump, never a queued branch.
    assign jump_capture = jump & (~pend_valid | ~pend_is_branch);

    always_comb begin
        next_pc = pc_plus4;
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= RUN;
            pc             <= PC_INIT;
            pend_valid     <= 1'b0;
            pend_target    <= '0;
            pend_is_branch <= 1'b0;
        end else if (running) begin
            if (halt) begin
                state <= HALTED;
            end else if (advance) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end else if (branch_taken) begin
                pend_target    <= branch_target;
                pend_valid     <= 1'b1;
                pend_is_branch <= 1'b1;
            end else if (jump_capture) begin
                pend_target    <= jump_target;
                pend_valid     <= 1'b1;
                pend_is_branch <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ifid        <= '0;
            fetch_count <= '0;
        end else if (!running || halt) begin
            ifid <= '0;
        end else if (flush_ifid) begin
            ifid <= '0;
        end else if (stall_ifid) begin
            ifid <= ifid;
        end else if (ihit) begin
            ifid.instr  <= imemload;
            ifid.pc4    <= pc_plus4;
            ifid.valid  <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end else begin
            ifid <= '0;
        end
    end

    assign imemaddr     = pc;
    assign imemREN      = running;
    assign fetch_halted = ~running;
    assign ifid_instr   = ifid.instr;
    assign ifid_pc4     = ifid.pc4;
    assign ifid_valid   = ifid.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en, stall_ifid, flush_ifid, ihit;
    logic [31:0] imemload;
    logic        branch_taken, jump, halt;
    logic [31:0] branch_target, jump_target;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] ifid_instr, ifid_pc4;
    logic        ifid_valid, fetch_halted;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.WORD_W(32), .PC_INIT(32'h0)) dut (
        .CLK(clk), .RST(rst),
        .pc_en(pc_en), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
        .ihit(ihit), .imemload(imemload),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .fetch_halted(fetch_halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: a pending redirect is a queue of at most one entry.
    typedef struct {
        logic [31:0] target;
        bit          from_branch;
    } redirect_t;

    redirect_t   pend_q[$];
    logic [31:0] m_pc;
    bit          m_halted;
    logic [31:0] m_instr, m_pc4;
    bit          m_valid;
    logic [31:0] m_cnt;

    function automatic void model_reset();
        m_pc = 32'h0;
        m_halted = 0;
        pend_q.delete();
        m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    endfunction

    function automatic void model_bubble();
        m_instr = 0; m_pc4 = 0; m_valid = 0;
    endfunction

    function automatic void model_step();
        redirect_t r;
        if (m_halted) begin
            model_bubble();
            return;
        end
        if (halt || flush_ifid) model_bubble();
        else if (stall_ifid) begin end
        else if (ihit) begin
            m_instr = imemload;
            m_pc4 = m_pc + 32'd4;
            m_valid = 1;
            m_cnt = m_cnt + 1;
        end else model_bubble();
        if (halt) begin
            m_halted = 1;
        end else if (pc_en && ihit) begin
            if (branch_taken) m_pc = branch_target;
            else if (jump) m_pc = jump_target;
            else if (pend_q.size() != 0) m_pc = pend_q[0].target;
            else m_pc = m_pc + 32'd4;
            pend_q.delete();
        end else if (branch_taken) begin
            r.target = branch_target;
            r.from_branch = 1;
            pend_q.delete();
            pend_q.push_back(r);
        end else if (jump) begin
            if (pend_q.size() == 0 || !pend_q[0].from_branch) begin
                r.target = jump_target;
                r.from_branch = 0;
                pend_q.delete();
                pend_q.push_back(r);
            end
        end
    endfunction

    task automatic drive(input bit pe, input bit ih, input bit st, input bit fl,
                         input bit br, input logic [31:0] bt,
                         input bit jp, input logic [31:0] jt,
                         input bit hl, input logic [31:0] im);
        pc_en = pe; ihit = ih; stall_ifid = st; flush_ifid = fl;
        branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; halt = hl; imemload = im;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        #12;
        total += 5;
        if (imemaddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imemaddr); end
        if (imemREN !== 1'b1) begin bad++; $display("FAIL reset_ren got=%b exp=1", imemREN); end
        if (fetch_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", fetch_halted); end
        if (ifid_valid !== 1'b0 || ifid_instr !== 0 || ifid_pc4 !== 0) begin
            bad++; $display("FAIL reset_ifid got=%b/%h/%h exp=0", ifid_valid, ifid_instr, ifid_pc4);
        end
        if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        rst = 1'b0;
    endtask

    task automatic test_seq_fetch();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0, $urandom());
            tick();
            total += 4;
            if (imemaddr !== 32'(4 * k) || imemaddr !== m_pc) begin
                bad++; $display("FAIL seq_addr got=%h exp=%h", imemaddr, 32'(4 * k));
            end
            if (ifid_pc4 !== 32'(4 * k)) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", ifid_pc4, 32'(4 * k)); end
            if (ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", ifid_valid); end
            if (ifid_instr !== m_instr) begin bad++; $display("FAIL seq_instr got=%h exp=%h", ifid_instr, m_instr); end
        end
        total++;
        if (fetch_count !== 32'd4) begin bad++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_ihit_low();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0, $urandom());
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, $urandom());
            tick();
            total += 3;
            if (imemaddr !== 32'h20) begin bad++; $display("FAIL nohit_addr got=%h exp=20", imemaddr); end
            if (ifid_valid !== 1'b0) begin bad++; $display("FAIL nohit_valid got=%b exp=0", ifid_valid); end
            if (fetch_count !== m_cnt || fetch_count !== 32'd8) begin
                bad++; $display("FAIL nohit_count got=%0d exp=8", fetch_count);
            end
        end
    endtask

    task automatic test_pending();
        drive(0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0);
        tick();
        total++;
        if (imemaddr !== 32'h20) begin bad++; $display("FAIL pend_hold got=%h exp=20", imemaddr); end
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
        tick();
        total++;
        if (imemaddr !== 32'h100) begin bad++; $display("FAIL pend_branch got=%h exp=100", imemaddr); end
        tick();
        total++;
        if (imemaddr !== 32'h104) begin bad++; $display("FAIL pend_clear got=%h exp=104", imemaddr); end
        // a lone jump captured while frozen is replayed too
        drive(0, 1, 0, 0, 0, 0, 1, 32'h300, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (imemaddr !== 32'h300) begin bad++; $display("FAIL pend_jump got=%h exp=300", imemaddr); end
    endtask

    task automatic test_flush_stall();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8C01_0004);
        tick();
        total++;
        if (ifid_instr !== 32'h8C01_0004) begin bad++; $display("FAIL load_instr got=%h exp=8c010004", ifid_instr); end
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        tick();
        total += 2;
        if (ifid_instr !== 32'h8C01_0004) begin bad++; $display("FAIL stall_hold got=%h exp=8c010004", ifid_instr); end
        if (ifid_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", ifid_valid); end
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        tick();
        total += 2;
        if (ifid_instr !== 32'h0) begin bad++; $display("FAIL flush_instr got=%h exp=0", ifid_instr); end
        if (ifid_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ifid_valid); end
    endtask

    task automatic test_branch_jump();
        drive(1, 1, 0, 0, 1, 32'h40, 1, 32'h80, 0, 0);
        tick();
        total++;
        if (imemaddr !== 32'h40) begin bad++; $display("FAIL br_vs_jmp got=%h exp=40", imemaddr); end
        drive(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        total += 2;
        if (imemaddr !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=0", imemaddr); end
        if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL pc4_wrap got=%h exp=0", ifid_pc4); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3) != 0, $urandom_range(3) != 0,
                  $urandom_range(6) == 0, $urandom_range(9) == 0,
                  $urandom_range(9) == 0, $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(6) == 0, $urandom() & 32'hFFFF_FFFC,
                  0, $urandom());
            tick();
            total += 6;
            if (imemaddr !== m_pc) begin bad++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, imemaddr, m_pc); end
            if (imemREN !== 1'b1) begin bad++; $display("FAIL rnd_ren i=%0d got=%b exp=1", i, imemREN); end
            if (ifid_instr !== m_instr) begin bad++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, ifid_instr, m_instr); end
            if (ifid_pc4 !== m_pc4) begin bad++; $display("FAIL rnd_pc4 i=%0d got=%h exp=%h", i, ifid_pc4, m_pc4); end
            if (ifid_valid !== m_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, ifid_valid, m_valid); end
            if (fetch_count !== m_cnt) begin bad++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, fetch_count, m_cnt); end
        end
    endtask

    task automatic test_halt();
        drive(1, 1, 0, 0, 1, 32'h30, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 1, 32'h500, 0, 0, 1, 32'h1111_1111);
        tick();
        total += 4;
        if (fetch_halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", fetch_halted); end
        if (imemREN !== 1'b0) begin bad++; $display("FAIL halt_ren got=%b exp=0", imemREN); end
        if (imemaddr !== 32'h30) begin bad++; $display("FAIL halt_addr got=%h exp=30", imemaddr); end
        if (ifid_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b exp=0", ifid_valid); end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, $urandom_range(1), 32'h600, 1, 32'h700, 0, $urandom());
            tick();
            total += 3;
            if (imemaddr !== 32'h30 || imemaddr !== m_pc) begin bad++; $display("FAIL halted_addr got=%h exp=30", imemaddr); end
            if (ifid_valid !== 1'b0) begin bad++; $display("FAIL halted_valid got=%b exp=0", ifid_valid); end
            if (fetch_count !== m_cnt) begin bad++; $display("FAIL halted_count got=%0d exp=%0d", fetch_count, m_cnt); end
        end
        rst = 1'b1;
        model_reset();
        #2;
        total += 4;
        if (imemaddr !== 32'h0) begin bad++; $display("FAIL rst_halt_addr got=%h exp=0", imemaddr); end
        if (imemREN !== 1'b1) begin bad++; $display("FAIL rst_halt_ren got=%b exp=1", imemREN); end
        if (fetch_halted !== 1'b0) begin bad++; $display("FAIL rst_halt_flag got=%b exp=0", fetch_halted); end
        if (fetch_count !== 32'h0) begin bad++; $display("FAIL rst_halt_count got=%0d exp=0", fetch_count); end
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (imemaddr !== 32'h4) begin bad++; $display("FAIL rst_resume got=%h exp=4", imemaddr); end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_seq_fetch();
        test_ihit_low();
        test_pending();
        test_flush_stall();
        test_branch_jump();
        test_random();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
